// File: rtl/epb_slave_responder_pkg.sv
// epb_pkg: EPB width constants, default timeout data and responder FSM states.
// No ports; imported by the responder interface and the responder.
package epb_pkg;

   localparam int EPB_DW   = 32;
   localparam int EPB_BEW  = 4;
   localparam int EPB_A_LO = 5;
   localparam int EPB_A_HI = 29;

   localparam logic [0:EPB_DW-1] EPB_TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_ACK,
      ST_RESP,
      ST_HOLD
   } epb_state_e;

endpackage

// File: rtl/epb_slave_responder_if.sv
// EPB pad-side and register-bus signals of the slave responder.
// slave: responder view; master: processor pads plus register bank view.
interface epb_slave_responder_if;
   import epb_pkg::*;

   logic                     epb_cs_n;
   logic                     epb_r_w_n;
   logic [0:EPB_BEW-1]       epb_be_n;
   logic [EPB_A_LO:EPB_A_HI] epb_addr;
   logic [0:EPB_DW-1]        epb_data_in;
   logic [0:EPB_DW-1]        epb_data_out;
   logic                     epb_data_oe_n;
   logic                     epb_rdy;

   logic [EPB_A_LO:EPB_A_HI] bus_addr;
   logic [0:EPB_BEW-1]       bus_be;
   logic [0:EPB_DW-1]        bus_wr_data;
   logic                     bus_wr_en;
   logic                     bus_rd_en;
   logic [0:EPB_DW-1]        bus_rd_data;
   logic                     bus_ack;
   logic                     bus_timeout;

   modport slave (
      input  epb_cs_n, epb_r_w_n, epb_be_n,
      input  epb_addr, epb_data_in,
      input  bus_rd_data, bus_ack,
      output epb_data_out, epb_data_oe_n, epb_rdy,
      output bus_addr, bus_be, bus_wr_data,
      output bus_wr_en, bus_rd_en, bus_timeout
   );

   modport master (
      output epb_cs_n, epb_r_w_n, epb_be_n,
      output epb_addr, epb_data_in,
      output bus_rd_data, bus_ack,
      input  epb_data_out, epb_data_oe_n, epb_rdy,
      input  bus_addr, bus_be, bus_wr_data,
      input  bus_wr_en, bus_rd_en, bus_timeout
   );

endinterface

// File: rtl/epb_slave_responder.sv
// EPB slave responder: turns chip-select cycles into register-bus strobes,
// returns read data with epb_rdy and owns the data-bus tristate enable.
// Ports: epb_clk, epb_rst_n (async, active low), io (EPB + register bus).
module epb_slave_responder
   import epb_pkg::*;
#(
   parameter int unsigned       TIMEOUT      = 255,
   parameter logic [0:EPB_DW-1] TIMEOUT_DATA = EPB_TIMEOUT_DATA
) (
   input logic                  epb_clk,
   input logic                  epb_rst_n,
   epb_slave_responder_if.slave io
);

   // Last WAIT_ACK count value; the counter is cleared in REQ.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);

   epb_state_e state, state_nx;

   logic                     cs_n_q;
   logic                     r_w_n_q;
   logic [0:EPB_BEW-1]       be_n_q;
   logic [EPB_A_LO:EPB_A_HI] addr_q;
   logic [0:EPB_DW-1]        din_q;

   logic                     armed;
   logic                     rd_q;
   logic                     abort_q;
   logic                     to_q;
   logic [7:0]               cnt;
   logic [0:EPB_DW-1]        rdata_q;
   logic [EPB_A_LO:EPB_A_HI] addr_l;
   logic [0:EPB_BEW-1]       be_l;
   logic [0:EPB_DW-1]        wdata_l;

   logic start;
   logic in_acc;
   logic ack_take;
   logic to_take;
   logic drive;

   // cs_n resets low so a chip select held across reset exit
   // cannot look like a fresh falling edge.
   always_ff @(posedge epb_clk or negedge epb_rst_n) begin
      if (!epb_rst_n) begin
         cs_n_q  <= 1'b0;
         r_w_n_q <= 1'b0;
         be_n_q  <= '0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         cs_n_q  <= io.epb_cs_n;
         r_w_n_q <= io.epb_r_w_n;
         be_n_q  <= io.epb_be_n;
         addr_q  <= io.epb_addr;
         din_q   <= io.epb_data_in;
      end
   end

   always_ff @(posedge epb_clk or negedge epb_rst_n) begin
      if (!epb_rst_n) state <= ST_IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_acc   = (state == ST_REQ) ||
                 (state == ST_WAIT_ACK);
      ack_take = in_acc && io.bus_ack;
      to_take  = (state == ST_WAIT_ACK) &&
                 !io.bus_ack && (cnt == TO_LAST);
      start    = (state == ST_IDLE) &&
                 armed && !cs_n_q;
      // Only an acknowledged, still-selected read drives the pads.
      drive    = rd_q && !abort_q && !cs_n_q &&
                 ((state == ST_RESP) ||
                  (state == ST_HOLD));

      unique case (state)
         ST_IDLE:
            if (start) state_nx = ST_REQ;
         ST_REQ:
            state_nx = io.bus_ack ? ST_RESP : ST_WAIT_ACK;
         ST_WAIT_ACK:
            if (ack_take || to_take) state_nx = ST_RESP;
         ST_RESP:
            state_nx = abort_q ? ST_IDLE : ST_HOLD;
         ST_HOLD:
            if (cs_n_q) state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase

      io.epb_rdy       = (state == ST_RESP);
      io.bus_timeout   = (state == ST_RESP) && to_q;
      io.bus_wr_en     = (state == ST_REQ) && !rd_q;
      io.bus_rd_en     = (state == ST_REQ) && rd_q;
      io.epb_data_oe_n = !drive;
      io.epb_data_out  = drive ? rdata_q : '0;
      io.bus_addr      = addr_l;
      io.bus_be        = be_l;
      io.bus_wr_data   = wdata_l;
   end

   always_ff @(posedge epb_clk or negedge epb_rst_n) begin
      if (!epb_rst_n) begin
         armed   <= 1'b0;
         rd_q    <= 1'b0;
         abort_q <= 1'b0;
         to_q    <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
         addr_l  <= '0;
         be_l    <= '0;
         wdata_l <= '0;
      end else begin
         // A new transfer needs cs_n seen high at least once.
         armed <= start ? 1'b0 : (armed | cs_n_q);

         if (start) begin
            addr_l  <= addr_q;
            be_l    <= ~be_n_q;
            wdata_l <= din_q;
            rd_q    <= r_w_n_q;
            abort_q <= 1'b0;
         end else if (in_acc && cs_n_q) begin
            abort_q <= 1'b1;
         end

         if (state == ST_REQ)
            cnt <= '0;
         else if (state == ST_WAIT_ACK)
            cnt <= cnt + 8'd1;

         if (ack_take) begin
            rdata_q <= io.bus_rd_data;
            to_q    <= 1'b0;
         end else if (to_take) begin
            rdata_q <= TIMEOUT_DATA;
            to_q    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_epb_slave_responder.sv
// Self-checking bench for epb_slave_responder with TIMEOUT = 16.
// Table-driven transfers plus reset, back-to-back and async-reset sequences.
module tb_epb_slave_responder;
   import epb_pkg::*;

   localparam int TO = 16;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   epb_slave_responder_if io();

   epb_slave_responder #(
      .TIMEOUT      (TO),
      .TIMEOUT_DATA (32'hDEAD_BEEF)
   ) dut (
      .epb_clk   (clk),
      .epb_rst_n (rst_n),
      .io        (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic                     rw_n;
      logic [EPB_A_LO:EPB_A_HI] addr;
      logic [0:3]               be_n;
      logic [0:31]              wdata;
      int                       ack_dly;
      logic [0:31]              rdata;
      int                       exp_rdy;
      logic                     exp_to;
      logic [0:3]               exp_be;
      logic [0:31]              exp_dout;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h",
                  name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check($sformatf("%s_status", tag),
            {27'b0, io.epb_rdy, io.bus_wr_en,
             io.bus_rd_en, io.bus_timeout,
             io.epb_data_oe_n},
            32'h1);
      check($sformatf("%s_dout", tag),
            io.epb_data_out, 32'h0);
      check($sformatf("%s_addr", tag),
            {7'b0, io.bus_addr}, 32'h0);
      check($sformatf("%s_be", tag),
            {28'b0, io.bus_be}, 32'h0);
      check($sformatf("%s_wdata", tag),
            io.bus_wr_data, 32'h0);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int          rdy_k  = -1;
      int          str_k  = -1;
      int          n_str  = 0;
      int          n_rdy  = 0;
      int          n_to   = 0;
      int          n_oe   = 0;
      logic        to_rdy = 1'b0;
      logic        str_rd = 1'b0;
      logic        oe_rel = 1'b0;
      logic [0:31] do_rdy = '0;
      logic [0:31] do_late = '0;
      logic [EPB_A_LO:EPB_A_HI] a_s = '0;
      logic [0:3]  be_s = '0;
      logic [0:31] wd_s = '0;

      @(negedge clk);
      io.epb_cs_n    = 1'b0;
      io.epb_r_w_n   = v.rw_n;
      io.epb_addr    = v.addr;
      io.epb_be_n    = v.be_n;
      io.epb_data_in = v.wdata;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         io.bus_ack     = (v.ack_dly >= 0) &&
                          (k == v.ack_dly + 1);
         io.bus_rd_data = io.bus_ack ? v.rdata : '0;
         if (io.bus_wr_en || io.bus_rd_en) begin
            n_str++;
            if (str_k < 0) begin
               str_k  = k;
               str_rd = io.bus_rd_en;
               a_s    = io.bus_addr;
               be_s   = io.bus_be;
               wd_s   = io.bus_wr_data;
            end
         end
         if (io.epb_rdy) begin
            n_rdy++;
            if (rdy_k < 0) begin
               rdy_k  = k;
               to_rdy = io.bus_timeout;
               do_rdy = io.epb_data_out;
            end
         end
         if (io.bus_timeout) n_to++;
         if (!io.epb_data_oe_n) n_oe++;
         if (rdy_k >= 0 && k == rdy_k + 2) begin
            do_late     = io.epb_data_out;
            io.epb_cs_n = 1'b1;
         end
         if (rdy_k >= 0 && k == rdy_k + 3)
            oe_rel = io.epb_data_oe_n;
         if (rdy_k >= 0 && k == rdy_k + 4) break;
      end
      io.bus_ack  = 1'b0;
      io.epb_cs_n = 1'b1;
      repeat (2) @(negedge clk);

      check($sformatf("v%0d_strobe_cnt", id), n_str, 1);
      check($sformatf("v%0d_strobe_k", id), str_k, 1);
      check($sformatf("v%0d_strobe_rd", id),
            {31'b0, str_rd}, {31'b0, v.rw_n});
      check($sformatf("v%0d_addr", id),
            {7'b0, a_s}, {7'b0, v.addr});
      check($sformatf("v%0d_be", id),
            {28'b0, be_s}, {28'b0, v.exp_be});
      check($sformatf("v%0d_wdata", id), wd_s, v.wdata);
      check($sformatf("v%0d_rdy_k", id), rdy_k, v.exp_rdy);
      check($sformatf("v%0d_rdy_cnt", id), n_rdy, 1);
      check($sformatf("v%0d_to_at_rdy", id),
            {31'b0, to_rdy}, {31'b0, v.exp_to});
      check($sformatf("v%0d_to_cnt", id),
            n_to, v.exp_to ? 1 : 0);
      check($sformatf("v%0d_dout_rdy", id),
            do_rdy, v.exp_dout);
      check($sformatf("v%0d_dout_hold", id),
            do_late, v.exp_dout);
      check($sformatf("v%0d_oe_cycles", id),
            n_oe, v.rw_n ? 3 : 0);
      check($sformatf("v%0d_oe_release", id),
            {31'b0, oe_rel}, 32'h1);
   endtask

   task automatic back_to_back();
      logic [2:0] exp_st [10] = '{
         3'b001, 3'b101, 3'b010, 3'b001, 3'b001,
         3'b101, 3'b010, 3'b001, 3'b001, 3'b001
      };
      logic [0:31] exp_do;

      @(negedge clk);
      io.epb_cs_n    = 1'b0;
      io.epb_r_w_n   = 1'b1;
      io.epb_addr    = 25'h0000040;
      io.epb_be_n    = 4'b0000;
      io.epb_data_in = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         exp_do = (k == 2) ? 32'h1111_1111 :
                  (k == 6) ? 32'h2222_2222 : 32'h0;
         check($sformatf("b2b_st_k%0d", k),
               {29'b0, io.bus_rd_en, io.epb_rdy,
                io.epb_data_oe_n},
               {29'b0, exp_st[k]});
         check($sformatf("b2b_dout_k%0d", k),
               io.epb_data_out, exp_do);
         if (k == 5)
            check("b2b_addr2", {7'b0, io.bus_addr},
                  32'h0000044);
         io.bus_ack     = (k == 1) || (k == 5);
         io.bus_rd_data = (k == 1) ? 32'h1111_1111 :
                          (k == 5) ? 32'h2222_2222 : '0;
         if (k == 2 || k == 6) io.epb_cs_n = 1'b1;
         if (k == 3) begin
            io.epb_cs_n = 1'b0;
            io.epb_addr = 25'h0000044;
         end
      end
      io.bus_ack  = 1'b0;
      io.epb_cs_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_in_hold();
      int n_str = 0;

      @(negedge clk);
      io.epb_cs_n    = 1'b0;
      io.epb_r_w_n   = 1'b1;
      io.epb_addr    = 25'h0ABCDEF;
      io.epb_be_n    = 4'b0000;
      io.epb_data_in = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         io.bus_ack     = (k == 1);
         io.bus_rd_data = (k == 1) ? 32'h1357_2468 : '0;
      end
      check("hold_oe_n", {31'b0, io.epb_data_oe_n}, 32'h0);
      check("hold_dout", io.epb_data_out, 32'h1357_2468);
      #2 rst_n = 1'b0;
      #1 check_reset("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (io.bus_wr_en || io.bus_rd_en) n_str++;
      end
      check("rst_hold_cs_low_strobes", n_str, 0);
      io.epb_cs_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n_str;
      n_str          = 0;
      rst_n          = 1'b0;
      io.epb_cs_n    = 1'b0;
      io.epb_r_w_n   = 1'b1;
      io.epb_be_n    = '1;
      io.epb_addr    = '0;
      io.epb_data_in = '0;
      io.bus_rd_data = '0;
      io.bus_ack     = 1'b0;

      vecs[0] = '{1'b0, 25'h0000100, 4'b0000, 32'h1234_5678,
                  0, 32'h0, 2, 1'b0, 4'b1111, 32'h0};
      vecs[1] = '{1'b1, 25'h0000200, 4'b0101, 32'h0,
                  3, 32'hCAFE_F00D, 5, 1'b0, 4'b1010,
                  32'hCAFE_F00D};
      vecs[2] = '{1'b1, 25'h0000300, 4'b0000, 32'h0,
                  -1, 32'h0, 17, 1'b1, 4'b1111,
                  32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 25'h0000304, 4'b1100, 32'h0,
                  15, 32'h0BAD_F00D, 17, 1'b0, 4'b0011,
                  32'h0BAD_F00D};
      vecs[4] = '{1'b0, 25'h1FFFFFF, 4'b1110, 32'hA5A5_A5A5,
                  1, 32'h0, 3, 1'b0, 4'b0001, 32'h0};
      vecs[5] = '{1'b0, 25'h0000010, 4'b0011, 32'h5A5A_0001,
                  -1, 32'h0, 17, 1'b1, 4'b1100, 32'h0};

      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (io.bus_wr_en || io.bus_rd_en) n_str++;
      end
      check("rst_exit_cs_low_strobes", n_str, 0);
      io.epb_cs_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
      back_to_back();
      reset_in_hold();
      run_vec(6, vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
